// File: rtl/compare_result_tracker_pkg.sv
// Shared types for the comparator result tracker:
// result class encodings and FSM state constants.
package compare_result_tracker_pkg;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_LT   = 2'b01;
    localparam logic [1:0] RES_EQ   = 2'b10;
    localparam logic [1:0] RES_GT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/compare_result_tracker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear;
// holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Clear,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (Inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count = count_q;

endmodule

// File: rtl/compare_result_tracker.sv
// Classifies comparator flag samples, keeps tallies and
// equal-run state, and latches a fault on inconsistent flags.
module compare_result_tracker
    import compare_result_tracker_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    input  logic             AeqB,
    input  logic             AgeqB,
    input  logic             AltB,
    input  logic             Clear,
    output logic             OutValid,
    output logic [1:0]       LastResult,
    output logic [CNT_W-1:0] EqCount,
    output logic [CNT_W-1:0] GtCount,
    output logic [CNT_W-1:0] LtCount,
    output logic             RunHit,
    output logic             Error
);

    localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);

    state_e     state_q;
    logic [3:0] run_q;
    logic [3:0] run_d;
    logic [1:0] last_q;
    logic [1:0] class_d;
    logic       out_valid_q;
    logic       run_hit_q;
    logic       error_q;

    logic consistent;
    logic is_eq;
    logic is_gt;
    logic is_lt;
    logic accept;

    assign consistent = (AgeqB == ~AltB) && (!AeqB || AgeqB);
    assign is_eq      = AeqB;
    assign is_gt      = AgeqB & ~AeqB;
    assign is_lt      = AltB;

    // Reset/Clear win over a coincident sample, so it is dropped.
    assign accept = InValid && consistent && (state_q != ST_FAULT)
                    && !Reset && !Clear;

    always_comb begin
        run_d   = '0;
        class_d = RES_LT;
        if (is_eq) begin
            class_d = RES_EQ;
            run_d   = (run_q == RUN_MAX) ? run_q : run_q + 4'd1;
        end else if (is_gt) begin
            class_d = RES_GT;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            state_q     <= ST_IDLE;
            run_q       <= '0;
            last_q      <= RES_NONE;
            out_valid_q <= 1'b0;
            run_hit_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_TRACK: begin
                    if (InValid) begin
                        if (consistent) begin
                            state_q     <= ST_TRACK;
                            out_valid_q <= 1'b1;
                            last_q      <= class_d;
                            run_q       <= run_d;
                            run_hit_q   <= (run_d == RUN_MAX);
                        end else begin
                            state_q <= ST_FAULT;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_FAULT;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_eq_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (Clear),
        .Inc   (accept && is_eq),
        .Count (EqCount)
    );

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (Clear),
        .Inc   (accept && is_gt),
        .Count (GtCount)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (Clear),
        .Inc   (accept && is_lt),
        .Count (LtCount)
    );

    assign OutValid   = out_valid_q;
    assign LastResult = last_q;
    assign RunHit     = run_hit_q;
    assign Error      = error_q;

endmodule

// File: tb/tb_compare_result_tracker.sv
// Directed-vector bench for compare_result_tracker
// (CNT_W = 3 so saturation is reachable quickly).
module tb_compare_result_tracker;

    localparam int CNT_W   = 3;
    localparam int RUN_LEN = 4;

    logic             Clock = 1'b0;
    logic             Reset = 1'b0;
    logic             InValid = 1'b0;
    logic             AeqB = 1'b0;
    logic             AgeqB = 1'b0;
    logic             AltB = 1'b0;
    logic             Clear = 1'b0;
    logic             OutValid;
    logic [1:0]       LastResult;
    logic [CNT_W-1:0] EqCount;
    logic [CNT_W-1:0] GtCount;
    logic [CNT_W-1:0] LtCount;
    logic             RunHit;
    logic             Error;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] F_EQ  = 3'b110;
    localparam logic [2:0] F_GT  = 3'b010;
    localparam logic [2:0] F_LT  = 3'b001;
    localparam logic [2:0] F_BAD = 3'b101;

    compare_result_tracker #(
        .CNT_W   (CNT_W),
        .RUN_LEN (RUN_LEN)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .InValid    (InValid),
        .AeqB       (AeqB),
        .AgeqB      (AgeqB),
        .AltB       (AltB),
        .Clear      (Clear),
        .OutValid   (OutValid),
        .LastResult (LastResult),
        .EqCount    (EqCount),
        .GtCount    (GtCount),
        .LtCount    (LtCount),
        .RunHit     (RunHit),
        .Error      (Error)
    );

    always #5 Clock = ~Clock;

    // Drive one cycle of inputs, then settle just after the edge.
    task automatic drive(input logic v, input logic [2:0] f,
                         input logic clr, input logic rst);
        @(negedge Clock);
        InValid = v;
        {AeqB, AgeqB, AltB} = f;
        Clear = clr;
        Reset = rst;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        checks++;
        if ({OutValid, LastResult, EqCount, GtCount, LtCount, RunHit, Error}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ov=%b lr=%b eq=%0d gt=%0d lt=%0d rh=%b err=%b, want all 0",
                     OutValid, LastResult, EqCount, GtCount, LtCount,
                     RunHit, Error);
        end
        drive(1'b1, F_EQ, 1'b1, 1'b0);
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL clear_drops_ov: got %b want 0", OutValid);
        end
        checks++;
        if (EqCount !== 3'd0 || LastResult !== 2'b00) begin
            errors++;
            $display("FAIL clear_drops_cnt: got eq=%0d lr=%b want 0/00",
                     EqCount, LastResult);
        end
        drive(1'b1, F_EQ, 1'b1, 1'b1);
        checks++;
        if (OutValid !== 1'b0 || EqCount !== 3'd0) begin
            errors++;
            $display("FAIL clear_reset_both: got ov=%b eq=%0d want 0/0",
                     OutValid, EqCount);
        end
    endtask

    task automatic test_classify();
        logic [2:0] fl [4];
        logic [1:0] exp_lr [4];
        fl = '{F_EQ, F_GT, F_LT, F_EQ};
        exp_lr = '{2'b10, 2'b11, 2'b01, 2'b10};
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fl[i], 1'b0, 1'b0);
            checks++;
            if (OutValid !== 1'b1 || LastResult !== exp_lr[i]) begin
                errors++;
                $display("FAIL classify_%0d: got ov=%b lr=%b want 1/%b",
                         i, OutValid, LastResult, exp_lr[i]);
            end
        end
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        checks++;
        if (OutValid !== 1'b0) begin
            errors++;
            $display("FAIL classify_idle_ov: got %b want 0", OutValid);
        end
        checks++;
        if (EqCount !== 3'd2 || GtCount !== 3'd1 || LtCount !== 3'd1) begin
            errors++;
            $display("FAIL classify_counts: got eq=%0d gt=%0d lt=%0d want 2/1/1",
                     EqCount, GtCount, LtCount);
        end
    endtask

    task automatic test_run();
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, F_EQ, 1'b0, 1'b0);
            checks++;
            if (RunHit !== 1'b0) begin
                errors++;
                $display("FAIL run_early_%0d: got %b want 0", i, RunHit);
            end
        end
        drive(1'b0, F_EQ, 1'b0, 1'b0);
        checks++;
        if (RunHit !== 1'b0 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL run_gap: got rh=%b ov=%b want 0/0",
                     RunHit, OutValid);
        end
        drive(1'b1, F_EQ, 1'b0, 1'b0);
        checks++;
        if (RunHit !== 1'b1 || OutValid !== 1'b1) begin
            errors++;
            $display("FAIL run_hit: got rh=%b ov=%b want 1/1",
                     RunHit, OutValid);
        end
        drive(1'b1, F_EQ, 1'b0, 1'b0);
        checks++;
        if (RunHit !== 1'b1) begin
            errors++;
            $display("FAIL run_hold: got %b want 1", RunHit);
        end
        drive(1'b1, F_GT, 1'b0, 1'b0);
        checks++;
        if (RunHit !== 1'b0 || OutValid !== 1'b1) begin
            errors++;
            $display("FAIL run_drop: got rh=%b ov=%b want 0/1",
                     RunHit, OutValid);
        end
        drive(1'b1, F_EQ, 1'b0, 1'b0);
        checks++;
        if (RunHit !== 1'b0) begin
            errors++;
            $display("FAIL run_restart: got %b want 0", RunHit);
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_eq;
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_eq = (i >= 6) ? 3'd7 : 3'(i + 1);
            drive(1'b1, F_EQ, 1'b0, 1'b0);
            checks++;
            if (OutValid !== 1'b1 || EqCount !== exp_eq
                || LastResult !== 2'b10) begin
                errors++;
                $display("FAIL sat_%0d: got ov=%b eq=%0d lr=%b want 1/%0d/10",
                         i, OutValid, EqCount, LastResult, exp_eq);
            end
        end
    endtask

    task automatic test_fault();
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        drive(1'b1, F_EQ, 1'b0, 1'b0);
        drive(1'b1, F_LT, 1'b0, 1'b0);
        drive(1'b1, F_BAD, 1'b0, 1'b0);
        checks++;
        if (Error !== 1'b1 || OutValid !== 1'b0) begin
            errors++;
            $display("FAIL fault_flag: got err=%b ov=%b want 1/0",
                     Error, OutValid);
        end
        checks++;
        if (EqCount !== 3'd1 || LtCount !== 3'd1 || GtCount !== 3'd0
            || LastResult !== 2'b01) begin
            errors++;
            $display("FAIL fault_frozen: got eq=%0d lt=%0d gt=%0d lr=%b want 1/1/0/01",
                     EqCount, LtCount, GtCount, LastResult);
        end
        drive(1'b1, F_GT, 1'b0, 1'b0);
        drive(1'b1, F_EQ, 1'b0, 1'b0);
        checks++;
        if (OutValid !== 1'b0 || EqCount !== 3'd1 || GtCount !== 3'd0
            || Error !== 1'b1) begin
            errors++;
            $display("FAIL fault_ignore: got ov=%b eq=%0d gt=%0d err=%b want 0/1/0/1",
                     OutValid, EqCount, GtCount, Error);
        end
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        checks++;
        if (Error !== 1'b0 || EqCount !== 3'd0 || LtCount !== 3'd0
            || LastResult !== 2'b00) begin
            errors++;
            $display("FAIL fault_clear: got err=%b eq=%0d lt=%0d lr=%b want 0/0/0/00",
                     Error, EqCount, LtCount, LastResult);
        end
        drive(1'b1, F_GT, 1'b0, 1'b0);
        checks++;
        if (OutValid !== 1'b1 || GtCount !== 3'd1) begin
            errors++;
            $display("FAIL fault_recover: got ov=%b gt=%0d want 1/1",
                     OutValid, GtCount);
        end
    endtask

    initial begin
        test_reset();
        test_classify();
        test_run();
        test_saturation();
        test_fault();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
